// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: MEM-stage bus request controller (IDLE/ISSUE/WAIT/RESP).
// Pipeline side: req_valid/cmd/addr/wdata in; req_stall, rsp_valid/data/err out.
// Memory side: proc2mem_command/addr/data out; mem2proc_response/data/tag in.
// Clock clk, synchronous active-high reset rst.
// Optional macro MEM_REQ_TIMEOUT_EN: abandon an access after TIMEOUT_CYCLES.
module mem_req_ctrl #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [1:0]  req_cmd,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [1:0]  proc2mem_command,
  output logic [31:0] proc2mem_addr,
  output logic [31:0] proc2mem_data,
  input  logic [3:0]  mem2proc_response,
  input  logic [31:0] mem2proc_data,
  input  logic [3:0]  mem2proc_tag
);

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_STORE = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  cmd_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  tag_q, tag_d;
  logic [31:0] rdata_q, cap_data;
  logic        err_q, cap_err;
  logic        latch, cap;
  logic        tmo;
  logic        new_req;

  assign new_req = req_valid && (req_cmd != BUS_NONE);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
  end

`ifdef MEM_REQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;

  // This cycle is the TIMEOUT_CYCLES-th one spent in ISSUE/WAIT.
  assign tmo = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q == IDLE) begin
      cnt_q <= '0;
    end else if (state_q == ISSUE || state_q == WAIT) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    tag_d    = tag_q;
    latch    = 1'b0;
    cap      = 1'b0;
    cap_data = '0;
    cap_err  = 1'b0;
    unique case (state_q)
      IDLE: begin
        tag_d = '0;
        if (new_req) begin
          latch   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (mem2proc_response != 4'd0) begin
          if (cmd_q == BUS_STORE) begin
            cap     = 1'b1;
            state_d = RESP;
          end else if (mem2proc_tag == mem2proc_response) begin
            cap      = 1'b1;
            cap_data = mem2proc_data;
            state_d  = RESP;
          end else begin
            tag_d   = mem2proc_response;
            state_d = WAIT;
          end
        end else if (tmo) begin
          cap     = 1'b1;
          cap_err = 1'b1;
          state_d = RESP;
        end
      end
      WAIT: begin
        if (mem2proc_tag != 4'd0 && mem2proc_tag == tag_q) begin
          cap      = 1'b1;
          cap_data = mem2proc_data;
          state_d  = RESP;
        end else if (tmo) begin
          cap     = 1'b1;
          cap_err = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        tag_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cmd_q   <= BUS_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      tag_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      if (latch) begin
        cmd_q   <= req_cmd;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (cap) begin
        rdata_q <= cap_data;
        err_q   <= cap_err;
      end
    end
  end

  assign req_stall = (state_q == IDLE && new_req)
                   || state_q == ISSUE || state_q == WAIT;
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rdata_q;
`ifdef MEM_REQ_TIMEOUT_EN
  assign rsp_err   = err_q;
`else
  assign rsp_err   = 1'b0;
`endif

  assign proc2mem_command = (state_q == ISSUE) ? cmd_q : BUS_NONE;
  assign proc2mem_addr    = (state_q == ISSUE) ? addr_q : '0;
  assign proc2mem_data    = (state_q == ISSUE) ? wdata_q : '0;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb_mem_req_ctrl: directed self-checking bench for mem_req_ctrl.
// Timeout scenario built when MEM_REQ_TIMEOUT_EN is defined.
module tb_mem_req_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [1:0]  req_cmd;
  logic [31:0] req_addr, req_wdata;
  logic        req_stall, rsp_valid, rsp_err;
  logic [31:0] rsp_data;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr, proc2mem_data;
  logic [3:0]  mem2proc_response, mem2proc_tag;
  logic [31:0] mem2proc_data;

  int pass_cnt = 0;
  int total    = 0;

  mem_req_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_cmd           (req_cmd),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .req_stall         (req_stall),
    .rsp_valid         (rsp_valid),
    .rsp_data          (rsp_data),
    .rsp_err           (rsp_err),
    .proc2mem_command  (proc2mem_command),
    .proc2mem_addr     (proc2mem_addr),
    .proc2mem_data     (proc2mem_data),
    .mem2proc_response (mem2proc_response),
    .mem2proc_data     (mem2proc_data),
    .mem2proc_tag      (mem2proc_tag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    req_valid         = 1'b0;
    req_cmd           = 2'd0;
    req_addr          = '0;
    req_wdata         = '0;
    mem2proc_response = '0;
    mem2proc_tag      = '0;
    mem2proc_data     = '0;
  endtask

  task automatic start(input logic [1:0] c, input logic [31:0] a,
                       input logic [31:0] d);
    req_valid = 1'b1;
    req_cmd   = c;
    req_addr  = a;
    req_wdata = d;
  endtask

  task automatic test_reset();
    clear_in();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    total++;
    if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || req_stall !== 1'b0) begin
      $display("FAIL reset_flags: got v=%b e=%b s=%b want 0 0 0",
               rsp_valid, rsp_err, req_stall);
    end else pass_cnt++;
    total++;
    if (proc2mem_command !== 2'd0 || proc2mem_addr !== 32'd0
        || rsp_data !== 32'd0) begin
      $display("FAIL reset_bus: got cmd=%0d addr=%h data=%h want 0 0 0",
               proc2mem_command, proc2mem_addr, rsp_data);
    end else pass_cnt++;
  endtask

  task automatic test_none();
    start(2'd0, 32'h40, 32'h1);
    #1;
    total++;
    if (req_stall !== 1'b0) begin
      $display("FAIL none_stall: got %b want 0", req_stall);
    end else pass_cnt++;
    tick();
    total++;
    if (proc2mem_command !== 2'd0 || req_stall !== 1'b0) begin
      $display("FAIL none_bus: got cmd=%0d s=%b want 0 0",
               proc2mem_command, req_stall);
    end else pass_cnt++;
    clear_in();
    tick();
  endtask

  task automatic test_load();
    int stalls;
    stalls = 0;
    start(2'd1, 32'h100, 32'h0);
    #1;
    if (req_stall) stalls++;
    tick();
    req_valid         = 1'b0;
    mem2proc_response = 4'd3;
    #1;
    if (req_stall) stalls++;
    total++;
    if (proc2mem_command !== 2'd1 || proc2mem_addr !== 32'h100) begin
      $display("FAIL load_issue: got cmd=%0d addr=%h want 1 00000100",
               proc2mem_command, proc2mem_addr);
    end else pass_cnt++;
    tick();
    mem2proc_response = 4'd0;
    #1;
    if (req_stall) stalls++;
    tick();
    mem2proc_tag  = 4'd3;
    mem2proc_data = 32'h12345678;
    #1;
    if (req_stall) stalls++;
    tick();
    clear_in();
    #1;
    if (req_stall) stalls++;
    total++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h12345678) begin
      $display("FAIL load_resp: got v=%b d=%h want 1 12345678",
               rsp_valid, rsp_data);
    end else pass_cnt++;
    total++;
    if (stalls != 4) begin
      $display("FAIL load_stall_cycles: got %0d want 4", stalls);
    end else pass_cnt++;
    tick();
    total++;
    if (rsp_valid !== 1'b0 || rsp_data !== 32'h12345678) begin
      $display("FAIL load_hold: got v=%b d=%h want 0 12345678",
               rsp_valid, rsp_data);
    end else pass_cnt++;
  endtask

  task automatic test_store();
    int bad;
    bad = 0;
    start(2'd2, 32'h200, 32'hCAFEF00D);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem2proc_response = (i == 3) ? 4'd5 : 4'd0;
      #1;
      if (proc2mem_command !== 2'd2 || proc2mem_addr !== 32'h200
          || proc2mem_data !== 32'hCAFEF00D || req_stall !== 1'b1) bad++;
      tick();
    end
    total++;
    if (bad != 0) begin
      $display("FAIL store_bus: got %0d bad issue cycles want 0", bad);
    end else pass_cnt++;
    mem2proc_response = 4'd0;
    start(2'd1, 32'h300, 32'h0);
    #1;
    total++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'd0 || req_stall !== 1'b0) begin
      $display("FAIL store_resp: got v=%b d=%h s=%b want 1 0 0",
               rsp_valid, rsp_data, req_stall);
    end else pass_cnt++;
    tick();
    clear_in();
    #1;
    total++;
    if (proc2mem_command !== 2'd0 || rsp_valid !== 1'b0) begin
      $display("FAIL resp_ignores_req: got cmd=%0d v=%b want 0 0",
               proc2mem_command, rsp_valid);
    end else pass_cnt++;
  endtask

  task automatic test_same_cycle();
    start(2'd1, 32'h180, 32'h0);
    tick();
    req_valid         = 1'b0;
    mem2proc_response = 4'd7;
    mem2proc_tag      = 4'd7;
    mem2proc_data     = 32'hA5A5A5A5;
    tick();
    clear_in();
    #1;
    total++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'hA5A5A5A5) begin
      $display("FAIL same_cycle: got v=%b d=%h want 1 a5a5a5a5",
               rsp_valid, rsp_data);
    end else pass_cnt++;
    tick();
  endtask

  task automatic test_foreign_tags();
    start(2'd1, 32'h1C0, 32'h0);
    tick();
    req_valid         = 1'b0;
    mem2proc_response = 4'd4;
    tick();
    mem2proc_response = 4'd0;
    mem2proc_tag      = 4'd2;
    mem2proc_data     = 32'h11111111;
    tick();
    mem2proc_tag  = 4'd0;
    mem2proc_data = 32'h22222222;
    #1;
    total++;
    if (rsp_valid !== 1'b0 || req_stall !== 1'b1) begin
      $display("FAIL foreign_tag2: got v=%b s=%b want 0 1",
               rsp_valid, req_stall);
    end else pass_cnt++;
    tick();
    mem2proc_tag  = 4'd4;
    mem2proc_data = 32'hDEADBEEF;
    #1;
    total++;
    if (rsp_valid !== 1'b0 || req_stall !== 1'b1) begin
      $display("FAIL foreign_tag0: got v=%b s=%b want 0 1",
               rsp_valid, req_stall);
    end else pass_cnt++;
    tick();
    clear_in();
    #1;
    total++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEADBEEF) begin
      $display("FAIL foreign_match: got v=%b d=%h want 1 deadbeef",
               rsp_valid, rsp_data);
    end else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_wait();
    start(2'd1, 32'h240, 32'h0);
    tick();
    req_valid         = 1'b0;
    mem2proc_response = 4'd6;
    tick();
    mem2proc_response = 4'd0;
    rst               = 1'b1;
    tick();
    rst           = 1'b0;
    mem2proc_tag  = 4'd6;
    mem2proc_data = 32'h66666666;
    #1;
    total++;
    if (req_stall !== 1'b0 || proc2mem_command !== 2'd0) begin
      $display("FAIL rst_wait_idle: got s=%b cmd=%0d want 0 0",
               req_stall, proc2mem_command);
    end else pass_cnt++;
    tick();
    clear_in();
    #1;
    total++;
    if (rsp_valid !== 1'b0 || rsp_data !== 32'd0) begin
      $display("FAIL rst_wait_stale: got v=%b d=%h want 0 0",
               rsp_valid, rsp_data);
    end else pass_cnt++;
    tick();
  endtask

`ifdef MEM_REQ_TIMEOUT_EN
  task automatic test_timeout();
    int  n;
    logic seen;
    n    = 0;
    seen = 1'b0;
    start(2'd1, 32'h280, 32'h0);
    tick();
    req_valid         = 1'b0;
    mem2proc_response = 4'd9;
    for (int i = 0; i < 20 && !seen; i++) begin
      #1;
      if (rsp_valid) seen = 1'b1;
      else begin
        if (req_stall) n++;
        tick();
        mem2proc_response = 4'd0;
      end
    end
    total++;
    if (!seen || n != 8) begin
      $display("FAIL timeout_cycles: got seen=%b n=%0d want 1 8", seen, n);
    end else pass_cnt++;
    total++;
    if (rsp_err !== 1'b1 || rsp_data !== 32'd0) begin
      $display("FAIL timeout_err: got e=%b d=%h want 1 0", rsp_err, rsp_data);
    end else pass_cnt++;
    tick();
    total++;
    if (rsp_valid !== 1'b0 || rsp_err !== 1'b1) begin
      $display("FAIL timeout_hold: got v=%b e=%b want 0 1", rsp_valid, rsp_err);
    end else pass_cnt++;
  endtask
`else
  task automatic test_no_timeout();
    int bad;
    bad = 0;
    start(2'd1, 32'h280, 32'h0);
    tick();
    req_valid         = 1'b0;
    mem2proc_response = 4'd9;
    tick();
    mem2proc_response = 4'd0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (rsp_valid !== 1'b0 || req_stall !== 1'b1 || rsp_err !== 1'b0) bad++;
      tick();
    end
    total++;
    if (bad != 0) begin
      $display("FAIL no_timeout_wait: got %0d bad cycles want 0", bad);
    end else pass_cnt++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1;
    clear_in();
    test_reset();
    test_none();
    test_load();
    test_store();
    test_same_cycle();
    test_foreign_tags();
    test_reset_wait();
`ifdef MEM_REQ_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
